// File: rtl/ball_pkg.sv
// Shared ball and screen definitions for the ball driver, ball_render and vga_driver.
package ball_pkg;
  localparam int unsigned SCREEN_W    = 1024;
  localparam int unsigned SCREEN_H    = 768;
  localparam int unsigned BALL_RADIUS = 16;
  localparam int unsigned VEC_W       = 4;
  localparam int unsigned X_W         = $clog2(SCREEN_W);
  localparam int unsigned Y_W         = $clog2(SCREEN_H);
  localparam int unsigned VEC_MAX_W   = 16;

  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_e;

  typedef struct packed {
    logic [X_W-1:0]          x;
    logic [Y_W-1:0]          y;
    logic signed [VEC_W-1:0] vx;
    logic signed [VEC_W-1:0] vy;
  } ball_t;

  // Negate a w-bit two's complement value held sign-extended; the most negative value saturates.
  function automatic logic signed [VEC_MAX_W-1:0] sat_neg(
    input logic signed [VEC_MAX_W-1:0] v,
    input int unsigned                 w
  );
    logic signed [VEC_MAX_W-1:0] lim;
    lim = VEC_MAX_W'(1) <<< (w - 1);
    return (v == -lim) ? lim - VEC_MAX_W'(1) : -v;
  endfunction
endpackage

// File: rtl/multi_ball_driver_if.sv
// Control, velocity-load and display-read signals of the multi-ball driver.
interface multi_ball_driver_if
  import ball_pkg::*;
#(
  parameter int unsigned width     = SCREEN_W,
  parameter int unsigned height    = SCREEN_H,
  parameter int unsigned num_balls = 4,
  parameter int unsigned vec_width = VEC_W
);
  localparam int unsigned XW = $clog2(width);
  localparam int unsigned YW = $clog2(height);
  localparam int unsigned IW = (num_balls > 1) ? $clog2(num_balls) : 1;

  logic                        move;
  logic [num_balls-1:0]        ball_en;
  logic                        load_en;
  logic [IW-1:0]               load_idx;
  logic signed [vec_width-1:0] load_vx;
  logic signed [vec_width-1:0] load_vy;
  logic [IW-1:0]               rd_idx;
  logic [XW-1:0]               rd_h_pos;
  logic [YW-1:0]               rd_v_pos;
  logic                        busy;
  logic                        done;
  logic                        overrun;

  modport master (
    output move, ball_en, load_en, load_idx, load_vx, load_vy, rd_idx,
    input  rd_h_pos, rd_v_pos, busy, done, overrun
  );

  modport slave (
    input  move, ball_en, load_en, load_idx, load_vx, load_vy, rd_idx,
    output rd_h_pos, rd_v_pos, busy, done, overrun
  );
endinterface

// File: rtl/ball_axis_step.sv
// Single-axis motion step: advance by the velocity, clamp at the walls and reflect the velocity.
module ball_axis_step
  import ball_pkg::*;
#(
  parameter int unsigned extent      = SCREEN_W,
  parameter int unsigned ball_radius = BALL_RADIUS,
  parameter int unsigned vec_width   = VEC_W,
  localparam int unsigned PW         = $clog2(extent)
) (
  input  logic [PW-1:0]               pos,
  input  logic signed [vec_width-1:0] vec,
  output logic [PW-1:0]               next_pos,
  output logic signed [vec_width-1:0] next_vec
);
  localparam int unsigned SW = PW + 2;
  localparam logic signed [SW-1:0] LO = SW'(ball_radius);
  localparam logic signed [SW-1:0] HI = SW'(extent - 1 - ball_radius);

  logic signed [SW-1:0]        np;
  logic signed [vec_width-1:0] neg_vec;

  always_comb begin
    np      = $signed({2'b00, pos}) + SW'(vec);
    neg_vec = vec_width'(sat_neg(VEC_MAX_W'(vec), vec_width));
    if (np < LO) begin
      next_pos = PW'(LO);
      next_vec = neg_vec;
    end else if (np > HI) begin
      next_pos = PW'(HI);
      next_vec = neg_vec;
    end else begin
      next_pos = PW'(np);
      next_vec = vec;
    end
  end
endmodule

// File: rtl/multi_ball_driver.sv
// N-ball motion driver: one ball per cycle into a working set, then an atomic commit to the display set.
module multi_ball_driver
  import ball_pkg::*;
#(
  parameter int unsigned width       = SCREEN_W,
  parameter int unsigned height      = SCREEN_H,
  parameter int unsigned num_balls   = 4,
  parameter int unsigned ball_radius = BALL_RADIUS,
  parameter int unsigned vec_width   = VEC_W,
  parameter int unsigned init_y      = height / 2
) (
  input  logic               clk,
  input  logic               reset_n,
  multi_ball_driver_if.slave bus
);
  localparam int unsigned XW = $clog2(width);
  localparam int unsigned YW = $clog2(height);
  localparam int unsigned IW = (num_balls > 1) ? $clog2(num_balls) : 1;

  typedef struct packed {
    logic [XW-1:0]               x;
    logic [YW-1:0]               y;
    logic signed [vec_width-1:0] vx;
    logic signed [vec_width-1:0] vy;
  } ball_s;

  state_e                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  ball_s                       work_q [num_balls];
  ball_s                       work_d [num_balls];
  logic [XW-1:0]               disp_x_q [num_balls];
  logic [YW-1:0]               disp_y_q [num_balls];
  logic                        done_q, done_d, overrun_q, overrun_d;
  logic                        commit, load_ok, rd_ok;
  ball_s                       cur;
  logic [XW-1:0]               step_x;
  logic [YW-1:0]               step_y;
  logic signed [vec_width-1:0] step_vx, step_vy;

  if (num_balls == (1 << IW)) begin : g_full_idx
    assign load_ok = 1'b1;
    assign rd_ok   = 1'b1;
  end else begin : g_part_idx
    assign load_ok = (bus.load_idx < IW'(num_balls));
    assign rd_ok   = (bus.rd_idx < IW'(num_balls));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE:    if (bus.move) begin
                 state_d = UPDATE;
                 idx_d   = '0;
               end
      UPDATE:  if (idx_q == IW'(num_balls - 1)) state_d = COMMIT;
               else                             idx_d   = idx_q + 1'b1;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q != IDLE);
    bus.done    = done_q;
    bus.overrun = overrun_q;
    commit      = (state_q == COMMIT);
    done_d      = commit;
    overrun_d   = overrun_q | (bus.move & (state_q != IDLE));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb cur = work_q[idx_q];

  ball_axis_step #(.extent(width), .ball_radius(ball_radius), .vec_width(vec_width)) u_step_x (
    .pos(cur.x), .vec(cur.vx), .next_pos(step_x), .next_vec(step_vx)
  );

  ball_axis_step #(.extent(height), .ball_radius(ball_radius), .vec_width(vec_width)) u_step_y (
    .pos(cur.y), .vec(cur.vy), .next_pos(step_y), .next_vec(step_vy)
  );

  // A load is applied after the step, so it overrides any bounce reflection of the same ball.
  always_comb begin
    work_d = work_q;
    if (state_q == UPDATE && bus.ball_en[idx_q]) begin
      work_d[idx_q] = '{x: step_x, y: step_y, vx: step_vx, vy: step_vy};
    end
    if (bus.load_en && load_ok) begin
      work_d[bus.load_idx].vx = bus.load_vx;
      work_d[bus.load_idx].vy = bus.load_vy;
    end
  end

  for (genvar g = 0; g < num_balls; g++) begin : g_ball
    localparam logic [XW-1:0] X0 = XW'((g + 1) * width / (num_balls + 1));
    localparam logic [YW-1:0] Y0 = YW'(init_y);
    localparam logic signed [vec_width-1:0] VX0 = (g % 2 == 0) ? vec_width'(1) : vec_width'(-1);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        work_q[g]   <= '{x: X0, y: Y0, vx: VX0, vy: vec_width'(1)};
        disp_x_q[g] <= X0;
        disp_y_q[g] <= Y0;
      end else begin
        work_q[g] <= work_d[g];
        if (commit) begin
          disp_x_q[g] <= work_q[g].x;
          disp_y_q[g] <= work_q[g].y;
        end
      end
    end
  end

  always_comb begin
    bus.rd_h_pos = '0;
    bus.rd_v_pos = '0;
    if (rd_ok) begin
      bus.rd_h_pos = disp_x_q[bus.rd_idx];
      bus.rd_v_pos = disp_y_q[bus.rd_idx];
    end
  end
endmodule

// File: tb/tb_multi_ball_driver.sv
// Self-checking bench for multi_ball_driver: reset table, directed corner sequences, random frames vs. a model.
module tb_multi_ball_driver;
  localparam int N  = 4;
  localparam int W  = 1024;
  localparam int H  = 768;
  localparam int R  = 16;
  localparam int VW = 4;
  localparam int IW = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  multi_ball_driver_if #(.width(W), .height(H), .num_balls(N), .vec_width(VW)) bus ();

  multi_ball_driver #(
    .width(W), .height(H), .num_balls(N), .ball_radius(R), .vec_width(VW), .init_y(H / 2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: whole-frame arithmetic on plain integers
  int mx [N], my [N], mvx [N], mvy [N], dx [N], dy [N];
  int m_ovr;

  typedef struct { int idx; int ex; int ey; } rd_vec_t;
  rd_vec_t tbl [N];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int neg(input int v);
    return (v == -(1 << (VW - 1))) ? (1 << (VW - 1)) - 1 : -v;
  endfunction

  task automatic axis(inout int p, inout int v, input int ext);
    int n;
    n = p + v;
    if (n < R) begin
      p = R;
      v = neg(v);
    end else if (n > ext - 1 - R) begin
      p = ext - 1 - R;
      v = neg(v);
    end else begin
      p = n;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = (i + 1) * W / (N + 1);
      my[i]  = H / 2;
      mvx[i] = (i % 2 == 1) ? -1 : 1;
      mvy[i] = 1;
      dx[i]  = mx[i];
      dy[i]  = my[i];
    end
    m_ovr = 0;
  endtask

  task automatic model_frame(input logic [N-1:0] en);
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        axis(mx[i], mvx[i], W);
        axis(my[i], mvy[i], H);
      end
      dx[i] = mx[i];
      dy[i] = my[i];
    end
  endtask

  task automatic check_display(input string tag);
    for (int i = 0; i < N; i++) begin
      bus.rd_idx = IW'(i);
      #1;
      chk($sformatf("%s x[%0d]", tag, i), int'(bus.rd_h_pos), dx[i]);
      chk($sformatf("%s y[%0d]", tag, i), int'(bus.rd_v_pos), dy[i]);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " busy"}, int'(bus.busy), 0);
    chk({tag, " done"}, int'(bus.done), 0);
    chk({tag, " overrun"}, int'(bus.overrun), 0);
    for (int i = 0; i < N; i++) begin
      bus.rd_idx = IW'(tbl[i].idx);
      #1;
      chk($sformatf("%s x[%0d]", tag, tbl[i].idx), int'(bus.rd_h_pos), tbl[i].ex);
      chk($sformatf("%s y[%0d]", tag, tbl[i].idx), int'(bus.rd_v_pos), tbl[i].ey);
    end
  endtask

  task automatic do_load(input int i, input int vx, input int vy);
    bus.load_en  = 1'b1;
    bus.load_idx = IW'(i);
    bus.load_vx  = VW'(vx);
    bus.load_vy  = VW'(vy);
    @(posedge clk); #1;
    bus.load_en = 1'b0;
    mvx[i] = vx;
    mvy[i] = vy;
  endtask

  // One pass; cycle k is k cycles after the move cycle. mv2: extra move cycle, ld_k: in-flight load cycle.
  task automatic run_frame(input logic [N-1:0] en, input int mv2, input int ld_k,
                           input int ld_i, input int ld_vx, input int ld_vy);
    bus.ball_en = en;
    bus.move    = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= N + 2; k++) begin
      bus.move    = (k == mv2);
      bus.load_en = (k == ld_k);
      if (k == ld_k) begin
        bus.load_idx = IW'(ld_i);
        bus.load_vx  = VW'(ld_vx);
        bus.load_vy  = VW'(ld_vy);
      end
      chk($sformatf("busy k=%0d", k), int'(bus.busy), (k <= N + 1) ? 1 : 0);
      chk($sformatf("done k=%0d", k), int'(bus.done), (k == N + 2) ? 1 : 0);
      chk($sformatf("overrun k=%0d", k), int'(bus.overrun), m_ovr);
      if (k == mv2) m_ovr = 1;
      if (k < N + 2) begin
        @(posedge clk); #1;
      end
    end
    bus.move    = 1'b0;
    bus.load_en = 1'b0;
    model_frame(en);
    if (ld_k > 0) begin
      mvx[ld_i] = ld_vx;
      mvy[ld_i] = ld_vy;
    end
    check_display("frame");
  endtask

  task automatic chk_ball(input string name, input int i, input int ex, input int ey);
    bus.rd_idx = IW'(i);
    #1;
    chk({name, " x"}, int'(bus.rd_h_pos), ex);
    if (ey >= 0) chk({name, " y"}, int'(bus.rd_v_pos), ey);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] en;
    int lk, li;

    tbl[0] = '{0, 204, 384};
    tbl[1] = '{1, 409, 384};
    tbl[2] = '{2, 614, 384};
    tbl[3] = '{3, 819, 384};

    bus.move     = 1'b0;
    bus.ball_en  = '1;
    bus.load_en  = 1'b0;
    bus.load_idx = '0;
    bus.load_vx  = '0;
    bus.load_vy  = '0;
    bus.rd_idx   = '0;
    model_reset();

    #12 reset_n = 1'b1;
    @(posedge clk); #1;
    check_reset("reset");

    // First frame: fixed latency and +/-1 steps
    run_frame('1, 0, 0, 0, 0, 0);
    chk_ball("f1 b0", 0, 205, 385);
    chk_ball("f1 b1", 1, 408, 385);

    // Ball 2 driven to x=1003, then the right-wall bounce
    do_load(2, 3, 1);
    run_frame('1, 0, 0, 0, 0, 0);
    do_load(2, 7, 1);
    repeat (55) run_frame('1, 0, 0, 0, 0, 0);
    chk_ball("b2 pre", 2, 1003, -1);
    run_frame('1, 0, 0, 0, 0, 0);
    chk_ball("b2 clamp", 2, 1007, -1);
    run_frame('1, 0, 0, 0, 0, 0);
    chk_ball("b2 back", 2, 1000, -1);

    // Ball 2 disabled for three frames
    repeat (3) run_frame(4'b1011, 0, 0, 0, 0, 0);
    chk_ball("b2 held", 2, 1000, -1);

    // Second move while busy: overrun set and sticky, single pass
    run_frame('1, 2, 0, 0, 0, 0);
    run_frame('1, 0, 0, 0, 0, 0);

    // Reset mid-pass clears everything, no commit follows
    bus.move = 1'b1;
    @(posedge clk); #1;
    bus.move = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset("midreset");
    reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < N + 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post-reset done k=%0d", k), int'(bus.done), 0);
      chk($sformatf("post-reset busy k=%0d", k), int'(bus.busy), 0);
    end
    check_display("post-reset");

    // Ball 1 to the left wall at -8: saturated reflection, then in-flight load overriding a bounce
    do_load(1, -8, 1);
    repeat (49) run_frame('1, 0, 0, 0, 0, 0);
    chk_ball("b1 pre", 1, 17, -1);
    run_frame('1, 0, 0, 0, 0, 0);
    chk_ball("b1 clamp", 1, 16, -1);
    run_frame('1, 0, 0, 0, 0, 0);
    chk_ball("b1 satneg", 1, 23, -1);
    do_load(1, -8, 1);
    run_frame('1, 0, 2, 1, 3, 1);
    chk_ball("b1 ldclamp", 1, 16, -1);
    run_frame('1, 0, 0, 0, 0, 0);
    chk_ball("b1 ldvel", 1, 19, -1);

    // Random frames, loads and enables against the model
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(2) == 0)
        do_load(int'($urandom_range(N - 1)), int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8);
      en = N'($urandom);
      li = int'($urandom_range(N - 1));
      lk = ($urandom_range(3) == 0) ? li + 1 : 0;
      run_frame(en, 0, lk, li, int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
